cpu_cmd_sequencer: RTL and testbench

- Upstream feeder for the 8-bit register/ALU CPU stage.
- Buffers host commands in a small FIFO and issues each one to the CPU as a correctly timed ce/load pulse.
- For operation commands, waits for the ALU write-back and returns the accumulator (register 0) value plus carry to the host through a valid/ready result port.
- Sits between the host/testbench command source and the CPU's data_in/opcode/cin/load/ce inputs.

---
 rtl/cpu_seq_pkg.sv | 20 ++
 rtl/cpu_cmd_fifo.sv | 54 +++++
 rtl/cpu_cmd_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cpu_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared constants for the CPU command sequencer: command field layout,
// default command width and the sequencer FSM state encoding.
package cpu_seq_pkg;

  localparam int CMD_W_DEFAULT = 17;

  localparam int CMD_LOAD_BIT = 16;
  localparam int CMD_CIN_BIT  = 15;
  localparam int CMD_OP_MSB   = 14;
  localparam int CMD_OP_LSB   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/cpu_cmd_fifo.sv
// Synchronous command FIFO for the sequencer; read data is taken directly
// from flop storage at the head pointer, so a pop consumes the visible word.
module cpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cpu_cmd_sequencer.sv
// Feeds buffered host commands to the register/ALU CPU as single ce pulses and
// returns accumulator results. Define CPU_SEQ_OP_COUNT_EN to add op_count.
module cpu_cmd_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CMD_W      = CMD_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [7:0]       cpu_data_in,
  output logic [6:0]       cpu_opcode,
  output logic             cpu_cin,
  output logic             cpu_load,
  output logic             cpu_ce,
  input  logic [7:0]       cpu_data_out,
  input  logic             cpu_cout,
  output logic [7:0]       res_data,
  output logic             res_cout,
  output logic             res_valid,
  input  logic             res_ready,
`ifdef CPU_SEQ_OP_COUNT_EN
  output logic             busy,
  output logic [15:0]      op_count
`else
  output logic             busy
`endif
);

  logic [CMD_W-1:0] fifo_rd_data;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

  seq_state_e state_q, state_d;
  logic [7:0] data_in_q, data_in_d;
  logic [6:0] opcode_q, opcode_d;
  logic       cin_q, cin_d;
  logic       load_q, load_d;
  logic       ce_q, ce_d;
  logic [7:0] res_data_q, res_data_d;
  logic       res_cout_q, res_cout_d;
  logic       res_valid_q, res_valid_d;
  logic       result_taken;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

  cpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (cmd_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    data_in_d    = data_in_q;
    opcode_d     = opcode_q;
    cin_d        = cin_q;
    load_d       = 1'b0;
    ce_d         = 1'b0;
    res_data_d   = res_data_q;
    res_cout_d   = res_cout_q;
    res_valid_d  = res_valid_q;
    result_taken = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // ce/load are set on entry to ISSUE so they are high only during ISSUE.
        if (!fifo_empty) begin
          data_in_d = fifo_rd_data[7:0];
          opcode_d  = fifo_rd_data[CMD_OP_MSB:CMD_OP_LSB];
          cin_d     = fifo_rd_data[CMD_CIN_BIT];
          load_d    = fifo_rd_data[CMD_LOAD_BIT];
          ce_d      = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_d = load_q ? ST_IDLE : ST_EXEC;
      ST_EXEC:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        res_data_d  = cpu_data_out;
        res_cout_d  = cpu_cout;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d  = 1'b0;
          result_taken = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_in_q   <= '0;
      opcode_q    <= '0;
      cin_q       <= 1'b0;
      load_q      <= 1'b0;
      ce_q        <= 1'b0;
      res_data_q  <= '0;
      res_cout_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_in_q   <= data_in_d;
      opcode_q    <= opcode_d;
      cin_q       <= cin_d;
      load_q      <= load_d;
      ce_q        <= ce_d;
      res_data_q  <= res_data_d;
      res_cout_q  <= res_cout_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cpu_data_in = data_in_q;
  assign cpu_opcode  = opcode_q;
  assign cpu_cin     = cin_q;
  assign cpu_load    = load_q;
  assign cpu_ce      = ce_q;
  assign res_data    = res_data_q;
  assign res_cout    = res_cout_q;
  assign res_valid   = res_valid_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

`ifdef CPU_SEQ_OP_COUNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (result_taken) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`else
  logic unused_result_taken;
  assign unused_result_taken = result_taken;
`endif

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Directed bench for cpu_cmd_sequencer with a small behavioural CPU: loads write
// a register, ops commit r0 = r0 + r[sel] + cin one cycle after ce.
module tb_cpu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cpu_data_in;
  logic [6:0]  cpu_opcode;
  logic        cpu_cin, cpu_load, cpu_ce;
  logic [7:0]  cpu_data_out;
  logic        cpu_cout;
  logic [7:0]  res_data;
  logic        res_cout, res_valid, res_ready, busy;
`ifdef CPU_SEQ_OP_COUNT_EN
  logic [15:0] op_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ce_count = 0;
  int last_op_ce_cyc = 0;
  logic prev_ce = 1'b0;
  logic prev_valid = 1'b0;

  logic [16:0] exp_issue_q[$];
  logic [8:0]  exp_res_q[$];

  always #5 clk = ~clk;

  cpu_cmd_sequencer #(.FIFO_DEPTH(4), .CMD_W(17)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cpu_data_in  (cpu_data_in),
    .cpu_opcode   (cpu_opcode),
    .cpu_cin      (cpu_cin),
    .cpu_load     (cpu_load),
    .cpu_ce       (cpu_ce),
    .cpu_data_out (cpu_data_out),
    .cpu_cout     (cpu_cout),
    .res_data     (res_data),
    .res_cout     (res_cout),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
`ifdef CPU_SEQ_OP_COUNT_EN
    .busy         (busy),
    .op_count     (op_count)
`else
    .busy         (busy)
`endif
  );

  // Behavioural CPU
  logic [7:0] m_regs [8];
  logic       m_pend = 1'b0;
  logic       m_cout = 1'b0;
  logic [8:0] m_sum;

  initial for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;

  assign m_sum        = {1'b0, m_regs[0]} + {1'b0, m_regs[cpu_opcode[6:4]]} + {8'd0, cpu_cin};
  assign cpu_data_out = m_regs[0];
  assign cpu_cout     = m_cout;

  always @(posedge clk) begin
    if (cpu_ce && cpu_load) m_regs[cpu_opcode[6:4]] <= cpu_data_in;
    m_pend <= cpu_ce && !cpu_load;
    if (m_pend) begin
      m_regs[0] <= m_sum[7:0];
      m_cout    <= m_sum[8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  // Monitor: samples after drivers settle, before the next active edge.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (!rst) begin
      if (cpu_ce) begin
        ce_count++;
        check("ce_gap", {31'd0, prev_ce}, 32'd0);
        if (exp_issue_q.size() == 0) begin
          check("stray_issue", 32'd1, 32'd0);
        end else begin
          check("issue_word", {15'd0, cpu_load, cpu_cin, cpu_opcode, cpu_data_in},
                {15'd0, exp_issue_q.pop_front()});
        end
        if (!cpu_load) last_op_ce_cyc = cyc;
      end
      if (res_valid && !prev_valid)
        check("res_latency", cyc - last_op_ce_cyc, 32'd3);
      if (res_valid && res_ready) begin
        if (exp_res_q.size() == 0) check("stray_result", 32'd1, 32'd0);
        else check("result", {23'd0, res_cout, res_data}, {23'd0, exp_res_q.pop_front()});
      end
    end
    prev_ce    = rst ? 1'b0 : cpu_ce;
    prev_valid = rst ? 1'b0 : res_valid;
  end

  task automatic push_cmd(input logic [16:0] c, input logic has_res, input logic [8:0] res);
    int n = 0;
    wait_neg();
    cmd_data  = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      wait_neg();
      n++;
    end
    check("push_timeout", {31'd0, cmd_ready}, 32'd1);
    if (cmd_ready) begin
      exp_issue_q.push_back(c);
      if (has_res) exp_res_q.push_back(res);
    end
    wait_neg();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_res_q.size() != 0 || exp_issue_q.size() != 0 || busy) && n < 500) begin
      wait_neg();
      n++;
    end
    check("drain_timeout", n, (n < 500) ? n : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int n;
    rst       = 1'b1;
    cmd_data  = '0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_neg();
    wait_neg();
    rst = 1'b0;

    // Reset values
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_cpu_ce",    {31'd0, cpu_ce},    32'd0);
    check("rst_cpu_load",  {31'd0, cpu_load},  32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data",  {24'd0, res_data},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
`ifdef CPU_SEQ_OP_COUNT_EN
    check("rst_op_count",  {16'd0, op_count},  32'd0);
`endif

    // Single load r3 = 0x5A: exactly one ce, no result
    c0 = ce_count;
    push_cmd(17'h1305A, 1'b0, 9'h000);
    wait_drain();
    check("single_load_ce_count", ce_count - c0, 32'd1);

    // Load r0, load r1, then ADD ops through r1
    push_cmd(17'h10010, 1'b0, 9'h000);
    push_cmd(17'h11022, 1'b0, 9'h000);
    push_cmd(17'h01000, 1'b1, 9'h032);
    push_cmd(17'h09000, 1'b1, 9'h055);
    push_cmd(17'h120F0, 1'b0, 9'h000);
    push_cmd(17'h02000, 1'b1, 9'h145);
    wait_drain();

    // Full FIFO and result backpressure
    res_ready = 1'b0;
    push_cmd(17'h01000, 1'b1, 9'h067);
    n = 0;
    while (!res_valid && n < 50) begin
      wait_neg();
      n++;
    end
    check("first_bp_valid", {31'd0, res_valid}, 32'd1);
    push_cmd(17'h01000, 1'b1, 9'h089);
    push_cmd(17'h01000, 1'b1, 9'h0AB);
    push_cmd(17'h01000, 1'b1, 9'h0CD);
    push_cmd(17'h01000, 1'b1, 9'h0EF);
    check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("full_busy",      {31'd0, busy},      32'd1);
    fork
      push_cmd(17'h01000, 1'b1, 9'h111);
      begin
        repeat (10) begin
          wait_neg();
          check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
          check("bp_no_ce",     {31'd0, cpu_ce},    32'd0);
          check("bp_res_valid", {31'd0, res_valid}, 32'd1);
          check("bp_res_data",  {24'd0, res_data},  32'h67);
        end
        res_ready = 1'b1;
        wait_neg();
        check("bp_release_idle",  {31'd0, cpu_ce}, 32'd0);
        wait_neg();
        check("bp_release_issue", {31'd0, cpu_ce}, 32'd1);
      end
    join
    wait_drain();
`ifdef CPU_SEQ_OP_COUNT_EN
    check("op_count_nine", {16'd0, op_count}, 32'd9);
`endif

    // Reset during EXEC: op is dropped, no result afterwards
    push_cmd(17'h01000, 1'b0, 9'h000);
    n = 0;
    while (!cpu_ce && n < 50) begin
      wait_neg();
      n++;
    end
    check("pre_rst_ce", {31'd0, cpu_ce}, 32'd1);
    wait_neg();
    rst = 1'b1;
    wait_neg();
    wait_neg();
    rst = 1'b0;
    check("mid_rst_cpu_ce",    {31'd0, cpu_ce},    32'd0);
    check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_busy",      {31'd0, busy},      32'd0);
`ifdef CPU_SEQ_OP_COUNT_EN
    check("mid_rst_op_count",  {16'd0, op_count},  32'd0);
`endif
    repeat (10) begin
      wait_neg();
      check("post_rst_no_valid", {31'd0, res_valid}, 32'd0);
    end

    // Normal operation resumes after reset
    push_cmd(17'h10001, 1'b0, 9'h000);
    push_cmd(17'h01000, 1'b1, 9'h023);
    wait_drain();
`ifdef CPU_SEQ_OP_COUNT_EN
    check("op_count_one", {16'd0, op_count}, 32'd1);
`endif

    repeat (3) wait_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
